// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and decoded-operation type for the up/down counter
//
// Purpose : mode constants and the priority-decoded operation enum shared by
//           param_updown_counter and counter_next_val.
// Contents: COUNT_WRAP / COUNT_SAT mode values, cnt_op_t operation enum.
package counter_pkg;

  localparam int unsigned COUNT_WRAP = 0;
  localparam int unsigned COUNT_SAT  = 1;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_DEC  = 3'd2,
    OP_LOAD = 3'd3,
    OP_CLR  = 3'd4
  } cnt_op_t;

endpackage

// File: rtl/counter_next_val.sv
// rtl/counter_next_val.sv - combinational next-count and boundary-event computation
//
// Purpose : given the current count and the decoded operation, produce the
//           next count and flag a boundary event (up at MAX_VAL / down at 0).
// Ports   : count      in  WIDTH  current registered count
//           op         in  3      decoded operation (cnt_op_t)
//           load_val   in  WIDTH  value for OP_LOAD, clamped to MAX_VAL
//           next_count out WIDTH  value to register on the next edge
//           boundary   out 1      wrap/saturation event this cycle
module counter_next_val
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE  = COUNT_WRAP,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic [WIDTH-1:0] count,
  input  cnt_op_t          op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary
);

  localparam logic [WIDTH:0]   MAX_EXT = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_W   = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W   = RESET_VAL[WIDTH-1:0];
  localparam bit               SAT_MODE = (SATURATE == COUNT_SAT);

  // One extra bit so the increment at MAX_VAL = 2**WIDTH-1 still compares
  // correctly instead of silently wrapping inside the adder.
  logic [WIDTH:0] inc_ext;
  assign inc_ext = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    next_count = count;
    boundary   = 1'b0;
    case (op)
      OP_INC: begin
        if (inc_ext > MAX_EXT) begin
          boundary   = 1'b1;
          next_count = SAT_MODE ? MAX_W : '0;
        end else begin
          next_count = inc_ext[WIDTH-1:0];
        end
      end
      OP_DEC: begin
        if (count == '0) begin
          boundary   = 1'b1;
          next_count = SAT_MODE ? '0 : MAX_W;
        end else begin
          next_count = count - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      OP_LOAD: next_count = (load_val > MAX_W) ? MAX_W : load_val;
      OP_CLR:  next_count = RST_W;
      default: next_count = count;
    endcase
  end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parametrised up/down counter with wrap/saturate, tc and sticky overflow
//
// Purpose : per-channel event/timestep counter. Holds the registers and the
//           reset > clear > load > en priority decode; arithmetic lives in
//           counter_next_val.
// Ports   : clk        in  1      rising-edge clock
//           reset      in  1      synchronous active-low reset
//           en, up     in  1      count enable / direction (1 = up)
//           load       in  1      load load_val (clamped to MAX_VAL)
//           load_val   in  WIDTH  value to load
//           clear      in  1      return to RESET_VAL
//           ovf_clr    in  1      clear ovf_sticky (a same-cycle event wins)
//           count      out WIDTH  registered count
//           tc         out 1      registered boundary pulse
//           at_max     out 1      count == MAX_VAL (combinational)
//           at_min     out 1      count == 0 (combinational)
//           ovf_sticky out 1      registered sticky boundary flag
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE  = COUNT_WRAP,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf_sticky
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "param_updown_counter: WIDTH must be 2..32");
  end
  if (MAX_VAL == 0 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $fatal(1, "param_updown_counter: MAX_VAL must be 1..2**WIDTH-1");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_rst
    $fatal(1, "param_updown_counter: RESET_VAL must be <= MAX_VAL");
  end
  if (SATURATE != COUNT_WRAP && SATURATE != COUNT_SAT) begin : g_bad_sat
    $fatal(1, "param_updown_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  cnt_op_t          op;
  logic             boundary;

  always_comb begin
    op = OP_HOLD;
    if (clear)     op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = up ? OP_INC : OP_DEC;
  end

  counter_next_val #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE),
    .RESET_VAL(RESET_VAL)
  ) u_next (
    .count     (count_q),
    .op        (op),
    .load_val  (load_val),
    .next_count(count_d),
    .boundary  (boundary)
  );

  always_comb begin
    tc_d  = boundary;
    // A boundary event in the same cycle as ovf_clr must leave the flag set.
    ovf_d = boundary | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= RST_W;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign tc         = tc_q;
  assign ovf_sticky = ovf_q;
  assign at_max     = (count_q == MAX_W);
  assign at_min     = (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - self-checking bench for param_updown_counter (wrap and saturate)
module tb_param_updown_counter;

  localparam int W      = 4;
  localparam int MAXV   = 9;
  localparam int RV_W   = 0;   // wrap instance reset value
  localparam int RV_S   = 3;   // saturate instance reset value

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0, up = 1'b0, load = 1'b0, clear = 1'b0, ovf_clr = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] cnt_w, cnt_s;
  logic         tc_w, tc_s, amax_w, amax_s, amin_w, amin_s, ovf_w, ovf_s;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(0), .RESET_VAL(RV_W)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .ovf_clr(ovf_clr), .count(cnt_w), .tc(tc_w), .at_max(amax_w),
    .at_min(amin_w), .ovf_sticky(ovf_w));

  param_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(1), .RESET_VAL(RV_S)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .ovf_clr(ovf_clr), .count(cnt_s), .tc(tc_s), .at_max(amax_s),
    .at_min(amin_s), .ovf_sticky(ovf_s));

  // Reference model: plain integer counter following the behavioural rules.
  int mc_w, mt_w, mo_w, mc_s, mt_s, mo_s;

  function automatic void model_step(input int sat, input int rv, input int c, input int o,
                                     output int nc, output int nt, output int no);
    int ev;
    ev = 0;
    nc = c;
    if (!reset) begin
      nc = rv; nt = 0; no = 0;
      return;
    end
    if (clear)     nc = rv;
    else if (load) nc = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
    else if (en && up) begin
      if (c >= MAXV) begin ev = 1; nc = sat ? MAXV : 0; end
      else nc = c + 1;
    end else if (en) begin
      if (c <= 0) begin ev = 1; nc = sat ? 0 : MAXV; end
      else nc = c - 1;
    end
    nt = ev;
    no = (ev != 0 || (o != 0 && !ovf_clr)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int c1, t1, o1, c2, t2, o2;
    model_step(0, RV_W, mc_w, mo_w, c1, t1, o1);
    model_step(1, RV_S, mc_s, mo_s, c2, t2, o2);
    mc_w <= c1; mt_w <= t1; mo_w <= o1;
    mc_s <= c2; mt_s <= t2; mo_s <= o2;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("w.count", int'(cnt_w), mc_w);
      chk("w.tc", int'(tc_w), mt_w);
      chk("w.ovf", int'(ovf_w), mo_w);
      chk("w.at_max", int'(amax_w), int'(mc_w == MAXV));
      chk("w.at_min", int'(amin_w), int'(mc_w == 0));
      chk("s.count", int'(cnt_s), mc_s);
      chk("s.tc", int'(tc_s), mt_s);
      chk("s.ovf", int'(ovf_s), mo_s);
      chk("s.at_max", int'(amax_s), int'(mc_s == MAXV));
      chk("s.at_min", int'(amin_s), int'(mc_s == 0));
    end
  end

  // Called at a negedge: apply inputs, return at the following negedge.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv,
                     input bit c, input bit oc);
    reset = r; en = e; up = u; load = l; load_val = lv[W-1:0]; clear = c; ovf_clr = oc;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    chk("rst.count", int'(cnt_w), 0);
    chk("rst.tc", int'(tc_w), 0);
    chk("rst.ovf", int'(ovf_w), 0);
    chk("rst.s.count", int'(cnt_s), RV_S);

    // 1: wrap up-count across MAX_VAL
    for (int k = 1; k <= 12; k++) begin
      cyc(1, 1, 1, 0, 0, 0, 0);
      if (k == 9)  chk("t1.at_max", int'(amax_w), 1);
      if (k == 10) begin
        chk("t1.wrap0", int'(cnt_w), 0);
        chk("t1.tc", int'(tc_w), 1);
        chk("t1.ovf", int'(ovf_w), 1);
      end
      if (k == 11) chk("t1.tc_off", int'(tc_w), 0);
      if (k == 12) chk("t1.count12", int'(cnt_w), 2);
    end

    // 2: load 3 then count down through 0
    cyc(1, 0, 0, 1, 3, 0, 0);
    chk("t2.load", int'(cnt_w), 3);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 0, 0, 0, 0, 0);
      if (k == 4) begin chk("t2.wrap9", int'(cnt_w), 9); chk("t2.tc", int'(tc_w), 1); end
      if (k == 5) begin chk("t2.count8", int'(cnt_w), 8); chk("t2.tc_off", int'(tc_w), 0); end
    end

    // 3: saturate at MAX_VAL, ovf_clr loses to a same-cycle event
    cyc(1, 0, 0, 1, 8, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 1, 1, 0, 0, 0, 0);
      chk("t3.sat_count", int'(cnt_s), 9);
      chk("t3.sat_tc", int'(tc_s), (k == 1) ? 0 : 1);
    end
    cyc(1, 1, 1, 0, 0, 0, 1);
    chk("t3.set_wins", int'(ovf_s), 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("t3.ovf_cleared", int'(ovf_s), 0);

    // 4: priority clear > load > en, then load > en
    cyc(1, 0, 0, 1, 5, 0, 0);
    cyc(1, 1, 1, 1, 7, 1, 0);
    chk("t4.clear", int'(cnt_w), RV_W);
    chk("t4.s.clear", int'(cnt_s), RV_S);
    cyc(1, 1, 1, 1, 7, 0, 0);
    chk("t4.load_no_inc", int'(cnt_w), 7);

    // 5: load clamp
    cyc(1, 0, 0, 1, 15, 0, 0);
    chk("t5.clamp", int'(cnt_w), 9);
    chk("t5.at_max", int'(amax_w), 1);
    chk("t5.tc", int'(tc_w), 0);
    chk("t5.ovf", int'(ovf_w), 0);

    // 6: reset on the same edge as a boundary event
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("t6.pre_ovf", int'(ovf_w), 1);
    cyc(1, 0, 0, 1, 9, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("t6.count", int'(cnt_w), 0);
    chk("t6.tc", int'(tc_w), 0);
    chk("t6.ovf", int'(ovf_w), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("t6.no_pulse", int'(tc_w), 0);

    // Random phase checked by the model every cycle
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
